// File: rtl/lfsr_step_ctrl.sv
// Command-driven sequencer for the 8-bit display LFSR: load seed, step N, free-run, stop.
// Define LFSR_ZERO_SEED_GUARD_EN to replace an all-zero seed with 8'h01 on LOAD.
module lfsr_step_ctrl #(
  parameter int          DIV_W    = 32,
  parameter int          CNT_W    = 16,
  parameter logic [7:0]  SEED_RST = 8'h01
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [CNT_W-1:0] cmd_arg,
  input  logic [DIV_W-1:0] div_val,
  output logic             lfsr_load,
  output logic [7:0]       lfsr_seed,
  output logic             lfsr_step,
  output logic             busy,
  output logic             done,
  output logic [1:0]       state_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_LOAD = 2'b01,
    S_STEP = 2'b10,
    S_RUN  = 2'b11
  } state_e;

  localparam logic [1:0] OP_STOP = 2'b00;
  localparam logic [1:0] OP_LOAD = 2'b01;
  localparam logic [1:0] OP_STEP = 2'b10;
  localparam logic [1:0] OP_RUN  = 2'b11;

  state_e           state_q, state_d;
  logic [DIV_W-1:0] tick_q, tick_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic [7:0]       seed_q, seed_d;
  logic             zdone_q, zdone_d;

  logic             ready_s, accept_s, active_s, tick_s;
  logic             load_s, step_s, done_s;
  logic [DIV_W-1:0] div_in_s;
  logic [7:0]       seed_in_s;

  assign ready_s  = (state_q == S_IDLE) || (state_q == S_RUN);
  assign accept_s = cmd_valid && ready_s;
  assign active_s = (state_q == S_STEP) || (state_q == S_RUN);
  assign tick_s   = active_s && (tick_q == (div_q - DIV_W'(1)));
  assign div_in_s = (div_val == '0) ? DIV_W'(1) : div_val;

`ifdef LFSR_ZERO_SEED_GUARD_EN
  // An all-zero seed would lock the XOR LFSR, so substitute the smallest live value.
  assign seed_in_s = (cmd_arg[7:0] == 8'h00) ? 8'h01 : cmd_arg[7:0];
`else
  assign seed_in_s = cmd_arg[7:0];
`endif

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    rem_d   = rem_q;
    seed_d  = seed_q;
    zdone_d = 1'b0;
    load_s  = 1'b0;
    step_s  = 1'b0;
    done_s  = zdone_q;
    if (tick_s) begin
      tick_d = '0;
    end else if (active_s) begin
      tick_d = tick_q + DIV_W'(1);
    end else begin
      tick_d = '0;
    end

    case (state_q)
      S_IDLE: begin
        state_d = S_IDLE;
      end
      S_LOAD: begin
        load_s  = 1'b1;
        done_s  = 1'b1;
        state_d = S_IDLE;
      end
      S_STEP: begin
        if (tick_s) begin
          step_s = 1'b1;
          rem_d  = rem_q - CNT_W'(1);
          if (rem_q == CNT_W'(1)) begin
            done_s  = 1'b1;
            state_d = S_IDLE;
          end else begin
            state_d = S_STEP;
          end
        end else begin
          state_d = S_STEP;
        end
      end
      S_RUN: begin
        // A command accepted here preempts the run, so its tick is swallowed.
        step_s = tick_s && !accept_s;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (accept_s) begin
      case (cmd_op)
        OP_STOP: state_d = S_IDLE;
        OP_LOAD: begin
          state_d = S_LOAD;
          seed_d  = seed_in_s;
        end
        OP_STEP: begin
          div_d  = div_in_s;
          tick_d = '0;
          if (cmd_arg == '0) begin
            state_d = S_IDLE;
            zdone_d = 1'b1;
          end else begin
            state_d = S_STEP;
            rem_d   = cmd_arg;
          end
        end
        OP_RUN: begin
          div_d   = div_in_s;
          tick_d  = '0;
          state_d = S_RUN;
        end
        default: state_d = S_IDLE;
      endcase
    end else begin
      zdone_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      tick_q  <= '0;
      div_q   <= DIV_W'(1);
      rem_q   <= '0;
      seed_q  <= SEED_RST;
      zdone_q <= 1'b0;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      div_q   <= div_d;
      rem_q   <= rem_d;
      seed_q  <= seed_d;
      zdone_q <= zdone_d;
    end
  end

  assign cmd_ready = ready_s;
  assign lfsr_load = load_s;
  assign lfsr_seed = seed_q;
  assign lfsr_step = step_s;
  assign busy      = (state_q != S_IDLE);
  assign done      = done_s;
  assign state_o   = state_q;

endmodule

// File: tb/tb_lfsr_step_ctrl.sv
// Directed bench for lfsr_step_ctrl: per-cycle expected output vectors go through a scoreboard queue.
module tb_lfsr_step_ctrl;
  localparam int DIV_W = 32;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [CNT_W-1:0] cmd_arg;
  logic [DIV_W-1:0] div_val;
  logic             lfsr_load;
  logic [7:0]       lfsr_seed;
  logic             lfsr_step;
  logic             busy;
  logic             done;
  logic [1:0]       state_o;

  lfsr_step_ctrl #(.DIV_W(DIV_W), .CNT_W(CNT_W), .SEED_RST(8'h01)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_arg(cmd_arg), .div_val(div_val),
    .lfsr_load(lfsr_load), .lfsr_seed(lfsr_seed), .lfsr_step(lfsr_step),
    .busy(busy), .done(done), .state_o(state_o)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;
  logic [14:0] exp_q[$];

  // {ready, load, step, busy, done, state[1:0], seed[7:0]}
  function automatic logic [14:0] ev(input logic rdy, input logic ld, input logic st,
                                     input logic bz, input logic dn, input logic [1:0] s,
                                     input logic [7:0] sd);
    return {rdy, ld, st, bz, dn, s, sd};
  endfunction

  task automatic drive(input logic v, input logic [1:0] op, input logic [CNT_W-1:0] arg,
                       input logic [DIV_W-1:0] dv);
    cmd_valid = v;
    cmd_op    = op;
    cmd_arg   = arg;
    div_val   = dv;
  endtask

  task automatic cyc(input string tag, input logic [14:0] e);
    logic [14:0] obs;
    logic [14:0] exp_v;
    exp_q.push_back(e);
    @(negedge clk);
    obs   = {cmd_ready, lfsr_load, lfsr_step, busy, done, state_o, lfsr_seed};
    exp_v = exp_q.pop_front();
    total++;
    assert (obs === exp_v) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] zseed;
`ifdef LFSR_ZERO_SEED_GUARD_EN
    zseed = 8'h01;
`else
    zseed = 8'h00;
`endif
    rst = 1'b1;
    drive(1'b0, 2'b00, 16'h0000, 32'd0);
    cyc("reset0", ev(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 8'h01));
    cyc("reset1", ev(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 8'h01));
    rst = 1'b0;

    // LOAD A5
    drive(1'b1, 2'b01, 16'h00A5, 32'd0);
    cyc("load_acc", ev(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 8'h01));
    drive(1'b0, 2'b00, 16'h0000, 32'd0);
    cyc("load_cyc", ev(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 2'b01, 8'hA5));
    cyc("load_idle", ev(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 8'hA5));

    // STEP N=3, D=4: steps in cycles 4, 8, 12 after accept
    drive(1'b1, 2'b10, 16'd3, 32'd4);
    cyc("step3_acc", ev(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 8'hA5));
    drive(1'b0, 2'b00, 16'h0000, 32'd0);
    for (int c = 1; c <= 12; c++)
      cyc($sformatf("step3_c%0d", c),
          ev(1'b0, 1'b0, (c % 4) == 0, 1'b1, c == 12, 2'b10, 8'hA5));
    cyc("step3_idle", ev(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 8'hA5));

    // STEP N=5, div 0 -> D=1, with a LOAD held pending throughout
    drive(1'b1, 2'b10, 16'd5, 32'd0);
    cyc("step5_acc", ev(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 8'hA5));
    drive(1'b1, 2'b01, 16'h0033, 32'd0);
    for (int c = 1; c <= 5; c++)
      cyc($sformatf("step5_c%0d", c), ev(1'b0, 1'b0, 1'b1, 1'b1, c == 5, 2'b10, 8'hA5));
    cyc("step5_ldacc", ev(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 8'hA5));
    drive(1'b0, 2'b00, 16'h0000, 32'd0);
    cyc("step5_load", ev(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 2'b01, 8'h33));
    cyc("step5_idle", ev(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 8'h33));

    // RUN D=2 then STOP in a cycle that would otherwise tick
    drive(1'b1, 2'b11, 16'h0000, 32'd2);
    cyc("run2_acc", ev(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 8'h33));
    drive(1'b0, 2'b00, 16'h0000, 32'd0);
    for (int c = 1; c <= 7; c++)
      cyc($sformatf("run2_c%0d", c), ev(1'b1, 1'b0, (c % 2) == 0, 1'b1, 1'b0, 2'b11, 8'h33));
    drive(1'b1, 2'b00, 16'h0000, 32'd0);
    cyc("run2_stop", ev(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'b11, 8'h33));
    drive(1'b0, 2'b00, 16'h0000, 32'd0);
    cyc("run2_idle", ev(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 8'h33));

    // RUN D=3 preempted by LOAD 00 in a tick cycle
    drive(1'b1, 2'b11, 16'h0000, 32'd3);
    cyc("run3_acc", ev(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 8'h33));
    drive(1'b0, 2'b00, 16'h0000, 32'd0);
    for (int c = 1; c <= 5; c++)
      cyc($sformatf("run3_c%0d", c), ev(1'b1, 1'b0, (c % 3) == 0, 1'b1, 1'b0, 2'b11, 8'h33));
    drive(1'b1, 2'b01, 16'hFF00, 32'd0);
    cyc("run3_ldacc", ev(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'b11, 8'h33));
    drive(1'b0, 2'b00, 16'h0000, 32'd0);
    cyc("run3_load", ev(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 2'b01, zseed));
    cyc("run3_idle0", ev(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, zseed));
    cyc("run3_idle1", ev(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, zseed));

    // STEP N=100 D=1 interrupted by reset after 40 steps
    drive(1'b1, 2'b10, 16'd100, 32'd1);
    cyc("step100_acc", ev(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, zseed));
    drive(1'b0, 2'b00, 16'h0000, 32'd0);
    for (int c = 1; c <= 40; c++)
      cyc($sformatf("step100_c%0d", c), ev(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'b10, zseed));
    rst = 1'b1;
    cyc("midrst0", ev(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 8'h01));
    cyc("midrst1", ev(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 8'h01));
    rst = 1'b0;
    cyc("postrst0", ev(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 8'h01));
    cyc("postrst1", ev(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 8'h01));

    // STEP N=0: done next cycle, no step, stays IDLE
    drive(1'b1, 2'b10, 16'd0, 32'd5);
    cyc("step0_acc", ev(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 8'h01));
    drive(1'b0, 2'b00, 16'h0000, 32'd0);
    cyc("step0_done", ev(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 8'h01));
    cyc("step0_idle", ev(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 8'h01));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/lfsr_step_ctrl.md
Name: lfsr_step_ctrl

Overview:
Sequencing controller for the 8-bit display LFSR datapath. It accepts commands over a valid/ready interface: load seed, step N times, free-run, stop. It drives the LFSR's load strobe, seed bus and single-cycle step-enable at a programmable tick rate. It replaces the hard-wired free-running divider, so firmware or test logic can step the pattern shown on the 7-segment pair deterministically.

Parameters:
DIV_W, 32, width of tick divider and div_val
CNT_W, 16, width of step count and cmd_arg; must be >= 8
SEED_RST, 8'h01, value of lfsr_seed during reset

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  asynchronous, active-high reset
cmd_valid  input  1  command present
cmd_ready  output  1  controller can accept a command this cycle
cmd_op  input  2  00 STOP, 01 LOAD, 10 STEP, 11 RUN
cmd_arg  input  CNT_W  LOAD: seed in [7:0]; STEP: step count; ignored otherwise
div_val  input  DIV_W  clocks per tick, sampled at command accept
lfsr_load  output  1  one-cycle strobe: LFSR loads lfsr_seed
lfsr_seed  output  8  seed value, valid while lfsr_load=1
lfsr_step  output  1  one-cycle strobe: LFSR advances one shift
busy  output  1  state is LOAD, STEP or RUN
done  output  1  one-cycle pulse: LOAD or STEP command finished
state_o  output  2  00 IDLE, 01 LOAD, 10 STEP, 11 RUN

Behaviour:
- Reset (rst=1, asynchronous): state IDLE; lfsr_load, lfsr_step, done, busy = 0; lfsr_seed = SEED_RST; tick and step counters = 0; latched divider = 1.
- Handshake: a command is accepted on a rising edge with cmd_valid & cmd_ready. cmd_ready is combinational: 1 in IDLE and RUN, 0 in LOAD and STEP. It is 1 while rst is asserted, because the reset state is IDLE. cmd_op/cmd_arg/div_val are sampled only on accept.
- Divider: the latched value is D = max(div_val, 1). The tick counter clears on accepting STEP or RUN and counts 0..D-1. A tick occurs when the counter is at D-1; the counter then wraps to 0.
- IDLE:
  - STOP: accepted, no effect.
  - LOAD: go to LOAD.
  - STEP with cmd_arg=0: stay IDLE; done=1 in the next cycle; no step.
  - STEP with N>0: go to STEP with remaining=N.
  - RUN: go to RUN.
- LOAD: exactly one cycle. lfsr_load=1, lfsr_seed=cmd_arg[7:0], done=1. Next state IDLE.
- STEP: lfsr_step=1 in each tick cycle, and remaining decrements on each tick.
  - On the tick where remaining=1: lfsr_step=1 and done=1 in the same cycle; next state IDLE.
  - The first step occurs D cycles after the accept edge. With D=1, steps occur on N consecutive cycles.
  - Non-abortable: only rst exits STEP early.
- RUN: lfsr_step=1 on every tick, indefinitely. done is never pulsed.
  - A new command is accepted in RUN and preempts it: STOP goes to IDLE; LOAD goes to LOAD; STEP/RUN restart the divider with the new div_val.
  - No lfsr_step is issued in the accept cycle.
- lfsr_load and lfsr_step are never both 1 in the same cycle.
- lfsr_seed holds its last loaded value outside LOAD.
- Reset mid-operation: an immediate return to the reset values; any in-flight step count is discarded.
- Step count arithmetic: unsigned CNT_W bits, no wrap, because decrement stops at 1 → IDLE.

Optional Feature:
Macro LFSR_ZERO_SEED_GUARD_EN.
- Defined: a LOAD with cmd_arg[7:0]=8'h00 drives lfsr_seed=8'h01, preventing all-zero lock-up of the XOR LFSR. All other seeds pass unchanged.
- Undefined: the seed passes through verbatim, including 8'h00.

Test Plan:
- Reset, then LOAD arg=8'hA5 → one cycle later lfsr_load=1, lfsr_seed=8'hA5, done=1; state_o returns to 00 the next cycle; cmd_ready=0 only during the LOAD cycle.
- STEP N=3, div_val=4 → lfsr_step pulses exactly 3 times, at 4, 8 and 12 cycles after accept; done coincides with the 3rd pulse; busy falls the next cycle.
- STEP N=5, div_val=0 → 5 consecutive lfsr_step cycles starting the cycle after accept (D=1); cmd_valid held high during STEP is not accepted until IDLE.
- RUN div_val=2, then STOP after 7 cycles → steps every 2nd cycle; no step in the STOP accept cycle; IDLE afterwards; no done pulse.
- RUN div_val=3, preempted by LOAD 8'h00 → with LFSR_ZERO_SEED_GUARD_EN, lfsr_seed=8'h01; without it, lfsr_seed=8'h00; the RUN ticks cease.
- STEP N=100, div_val=1, rst asserted at step 40 → outputs go to reset values immediately; no further lfsr_step; STEP N=0 afterwards → done one cycle after accept, no step.
